mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one variable-latency memory bus between the instruction-fetch port and the load/store data port of the 5-stage pipeline.
- Sequences one bus transaction at a time.
- Holds completed results stable while the pipeline is stalled.
- Generates the rom_wait and ram_wait stall inputs consumed by the hazard unit.
- Data accesses take priority; a starvation counter guarantees forward progress for fetch.

Parameters:
ADDR_WIDTH, 32, width of all address buses
DATA_WIDTH, 32, width of all data buses (byte enables = DATA_WIDTH/8)
STARVE_LIMIT, 4, consecutive data grants with fetch pending before fetch is forced to win (range 1..15)

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
if_req  input  1  fetch request; held with if_addr stable while rom_wait=1
if_addr  input  ADDR_WIDTH  fetch address
if_rdata  output  DATA_WIDTH  registered fetch data, valid when if_req=1 and rom_wait=0
rom_wait  output  1  fetch not yet complete
dm_req  input  1  data request; held with dm_* stable while ram_wait=1
dm_we  input  1  1=store, 0=load
dm_be  input  DATA_WIDTH/8  store byte enables
dm_addr  input  ADDR_WIDTH  data address
dm_wdata  input  DATA_WIDTH  store data
dm_rdata  output  DATA_WIDTH  registered load data, valid when dm_req=1 and ram_wait=0
ram_wait  output  1  data access not yet complete
bus_req  output  1  memory transaction active
bus_we  output  1  transaction is a write
bus_be  output  DATA_WIDTH/8  byte enables (all ones for fetch and loads)
bus_addr  output  ADDR_WIDTH  transaction address
bus_wdata  output  DATA_WIDTH  write data
bus_ack  input  1  one-cycle completion pulse from memory
bus_rdata  input  DATA_WIDTH  read data, valid in the bus_ack cycle

Behaviour:
- State machine: IDLE, FETCH, DATA.
- bus_req = (state != IDLE). bus_we, bus_be, bus_addr and bus_wdata are registered at grant and held constant until the ack.
- IDLE, pending defined as if_pend = if_req & ~if_done and dm_pend = dm_req & ~dm_done:
  - dm_pend & (~if_pend | starve_cnt < STARVE_LIMIT) -> DATA; starve_cnt++ if if_pend, else starve_cnt=0.
  - otherwise if_pend -> FETCH; starve_cnt=0.
  - neither pending -> stay in IDLE.
- FETCH/DATA: wait for bus_ack, then return to IDLE. There is no timeout. Back-to-back grants are separated by one IDLE cycle.
- On ack in FETCH:
  - if_rdata <= bus_rdata.
  - if_done <= if_req; if the request was withdrawn, the result is discarded.
- On ack in DATA:
  - dm_done <= dm_req.
  - dm_rdata <= bus_rdata only if the access was a load; stores leave dm_rdata unchanged.
- Stall outputs (combinational from registers and inputs):
  - rom_wait = if_req & ~if_done
  - ram_wait = dm_req & ~dm_done
- Advance cycle (pipeline moves) = ~rom_wait & ~ram_wait. On an advance cycle, if_done and dm_done clear, so the next request is treated as new.
- Partial completion: if one port is done and the other is still waiting, the done flag and its data register are held, and the completed access is not reissued.
- Minimum latency: request in cycle 0 (IDLE), bus_req in cycle 1, ack in cycle 1 -> wait low in cycle 2.
- bus_ack while in IDLE is ignored.
- Reset values:
  - state=IDLE, bus_req=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0.
  - if_rdata=0, dm_rdata=0, if_done=0, dm_done=0, starve_cnt=0.
  - Consequently rom_wait=if_req and ram_wait=dm_req.
- Reset mid-transaction: state returns to IDLE immediately. A late bus_ack is ignored, and the access is reissued after reset if still requested.

Test Plan:
- Fetch only: if_req=1, if_addr=0x100; memory acks 3 cycles after bus_req with 0x00000013 -> bus_addr=0x100, bus_be=0xF, bus_we=0; rom_wait high 4 cycles, then if_rdata=0x00000013 and rom_wait=0.
- Collision: if_req and dm_req (load, 0x2000) asserted in the same cycle -> DATA granted first with bus_addr=0x2000; dm_done set and ram_wait low while rom_wait stays high; FETCH follows; advance only after both complete; the data access is not reissued.
- Store: dm_we=1, dm_be=0x3, dm_wdata=0xDEADBEEF, dm_addr=0x40 -> bus_we=1, bus_be=0x3, bus_wdata=0xDEADBEEF; dm_rdata unchanged after the ack.
- Starvation: dm_req held as a new load every advance while if_req pending, STARVE_LIMIT=4 -> after 4 consecutive DATA grants, the 5th grant is FETCH; starve_cnt returns to 0.
- Reset in DATA state before ack, then ack arrives the cycle after reset -> bus_req=0, ack ignored, if_done=dm_done=0; after reset deasserts, the request is re-granted.
- Withdrawn fetch: if_req dropped during FETCH, then ack arrives -> if_done stays 0, no spurious advance, rom_wait=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbitrates one variable-latency memory bus between the fetch and load/store ports.
// Data accesses win unless fetch has lost STARVE_LIMIT consecutive grants.
module mem_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      if_req,
    input  logic [ADDR_WIDTH-1:0]     if_addr,
    output logic [DATA_WIDTH-1:0]     if_rdata,
    output logic                      rom_wait,
    input  logic                      dm_req,
    input  logic                      dm_we,
    input  logic [DATA_WIDTH/8-1:0]   dm_be,
    input  logic [ADDR_WIDTH-1:0]     dm_addr,
    input  logic [DATA_WIDTH-1:0]     dm_wdata,
    output logic [DATA_WIDTH-1:0]     dm_rdata,
    output logic                      ram_wait,
    output logic                      bus_req,
    output logic                      bus_we,
    output logic [DATA_WIDTH/8-1:0]   bus_be,
    output logic [ADDR_WIDTH-1:0]     bus_addr,
    output logic [DATA_WIDTH-1:0]     bus_wdata,
    input  logic                      bus_ack,
    input  logic [DATA_WIDTH-1:0]     bus_rdata
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

    state_t     state;
    logic       if_done;
    logic       dm_done;
    logic [3:0] starve_cnt;
    logic       if_pend;
    logic       dm_pend;
    logic       advance;
    logic       data_wins;

    assign if_pend   = if_req & ~if_done;
    assign dm_pend   = dm_req & ~dm_done;
    assign rom_wait  = if_pend;
    assign ram_wait  = dm_pend;
    assign advance   = ~if_pend & ~dm_pend;
    assign data_wins = dm_pend & (~if_pend | (starve_cnt < STARVE_MAX));
    assign bus_req   = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            bus_we     <= 1'b0;
            bus_be     <= '0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
            if_done    <= 1'b0;
            dm_done    <= 1'b0;
            starve_cnt <= '0;
        end else begin
            // Done flags live until the pipeline advances; an ack can only set a
            // flag while its port is still waiting, so it never collides with the clear.
            if (advance) begin
                if_done <= 1'b0;
                dm_done <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (data_wins) begin
                        state      <= DATA;
                        bus_we     <= dm_we;
                        bus_be     <= dm_we ? dm_be : '1;
                        bus_addr   <= dm_addr;
                        bus_wdata  <= dm_wdata;
                        starve_cnt <= if_pend ? starve_cnt + 4'd1 : '0;
                    end else if (if_pend) begin
                        state      <= FETCH;
                        bus_we     <= 1'b0;
                        bus_be     <= '1;
                        bus_addr   <= if_addr;
                        bus_wdata  <= '0;
                        starve_cnt <= '0;
                    end
                end
                FETCH: begin
                    if (bus_ack) begin
                        state    <= IDLE;
                        if_rdata <= bus_rdata;
                        if_done  <= if_req;
                    end
                end
                DATA: begin
                    if (bus_ack) begin
                        state   <= IDLE;
                        dm_done <= dm_req;
                        if (!bus_we) begin
                            dm_rdata <= bus_rdata;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table plus hand-written corner sequences,
// with a grant scoreboard fed by a behavioural memory responder.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk;
    logic          reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          rom_wait;
    logic          dm_req;
    logic          dm_we;
    logic [3:0]    dm_be;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;
    logic          ram_wait;
    logic          bus_req;
    logic          bus_we;
    logic [3:0]    bus_be;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic          bus_ack;
    logic [DW-1:0] bus_rdata;

    mem_arbiter #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .STARVE_LIMIT(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .rom_wait (rom_wait),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_be    (dm_be),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_rdata (dm_rdata),
        .ram_wait (ram_wait),
        .bus_req  (bus_req),
        .bus_we   (bus_we),
        .bus_be   (bus_be),
        .bus_addr (bus_addr),
        .bus_wdata(bus_wdata),
        .bus_ack  (bus_ack),
        .bus_rdata(bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        dm_req;
        logic        dm_we;
        logic [3:0]  dm_be;
        logic [31:0] dm_addr;
        logic [31:0] dm_wdata;
        int          lat;
        logic [31:0] exp_if;
        logic [31:0] exp_dm;
        int          exp_if_w;
        int          exp_dm_w;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    txn_t exp_q[$];

    // Written only by the memory responder, read by the main process.
    txn_t obs_a[256];
    int   obs_n = 0;
    int   hold_err = 0;
    int   obs_rd = 0;

    // Written only by the main process, read by the memory responder.
    int   lat = 0;
    bit   mem_hold = 1'b0;
    bit   force_ack = 1'b0;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'h0000_0013;
        return {~a[15:0], a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drain();
        txn_t o;
        txn_t e;
        while (obs_rd < obs_n) begin
            o = obs_a[obs_rd % 256];
            obs_rd++;
            chk("grant_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("grant_we", 64'(o.we), 64'(e.we));
                chk("grant_be", 64'(o.be), 64'(e.be));
                chk("grant_addr", 64'(o.addr), 64'(e.addr));
                if (e.we) chk("grant_wdata", 64'(o.wdata), 64'(e.wdata));
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        #1;
        drain();
    endtask

    // Memory responder: acks `lat` cycles into a transaction, logs every grant.
    initial begin
        int   cnt;
        bit   active;
        txn_t cur;
        cnt = 0;
        active = 1'b0;
        cur = '{we: 1'b0, be: 4'h0, addr: 32'h0, wdata: 32'h0};
        bus_ack = 1'b0;
        bus_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            bus_ack = 1'b0;
            if (!bus_req) begin
                active = 1'b0;
                cnt = 0;
            end else begin
                if (!active) begin
                    active = 1'b1;
                    cnt = 0;
                    cur = '{we: bus_we, be: bus_be, addr: bus_addr, wdata: bus_wdata};
                    obs_a[obs_n % 256] = cur;
                    obs_n++;
                end else if (bus_we !== cur.we || bus_be !== cur.be || bus_addr !== cur.addr ||
                             bus_wdata !== cur.wdata) begin
                    hold_err++;
                end
                if (!mem_hold && cnt == lat) begin
                    bus_ack = 1'b1;
                    bus_rdata = mem_f(bus_addr);
                end
                cnt++;
            end
            if (force_ack) begin
                bus_ack = 1'b1;
                bus_rdata = 32'hBAD0_BAD0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        vec_t v;
        bit   done;
        bit   got;
        int   if_w;
        int   dm_w;

        vecs[0] = '{1'b1, 32'h100, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 2,
                    mem_f(32'h100), 32'h0, 4, -1};
        vecs[1] = '{1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h2000, 32'h0, 0,
                    32'h0, mem_f(32'h2000), -1, 2};
        vecs[2] = '{1'b0, 32'h0, 1'b1, 1'b1, 4'h3, 32'h40, 32'hDEADBEEF, 1,
                    32'h0, mem_f(32'h2000), -1, 3};
        vecs[3] = '{1'b1, 32'h104, 1'b1, 1'b0, 4'h0, 32'h2004, 32'h0, 1,
                    mem_f(32'h104), mem_f(32'h2004), 6, 3};
        vecs[4] = '{1'b1, 32'h108, 1'b1, 1'b1, 4'hC, 32'h44, 32'h12345678, 3,
                    mem_f(32'h108), mem_f(32'h2004), -1, -1};
        vecs[5] = '{1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'hFFFF_FFFC, 32'h0, 0,
                    32'h0, mem_f(32'hFFFF_FFFC), -1, 2};

        reset = 1'b1;
        if_req = 1'b1;
        if_addr = '0;
        dm_req = 1'b0;
        dm_we = 1'b0;
        dm_be = '0;
        dm_addr = '0;
        dm_wdata = '0;

        // Reset values; wait outputs follow the requests directly.
        repeat (2) step();
        sample();
        chk("rst_rom_wait", 64'(rom_wait), 64'd1);
        chk("rst_ram_wait", 64'(ram_wait), 64'd0);
        chk("rst_bus_ctl", 64'({bus_req, bus_we, bus_be}), 64'd0);
        chk("rst_bus_addr", 64'(bus_addr), 64'd0);
        chk("rst_bus_wdata", 64'(bus_wdata), 64'd0);
        chk("rst_rdata", {if_rdata, dm_rdata}, 64'd0);

        // Stray ack while idle must be ignored.
        step();
        reset = 1'b0;
        if_req = 1'b0;
        sample();
        force_ack = 1'b1;
        step();
        sample();
        force_ack = 1'b0;
        step();
        sample();
        chk("idle_ack_bus_req", 64'(bus_req), 64'd0);
        chk("idle_ack_rdata", {if_rdata, dm_rdata}, 64'd0);

        for (int i = 0; i < 6; i++) begin
            v = vecs[i];
            step();
            lat = v.lat;
            if_req = v.if_req;
            if_addr = v.if_addr;
            dm_req = v.dm_req;
            dm_we = v.dm_we;
            dm_be = v.dm_be;
            dm_addr = v.dm_addr;
            dm_wdata = v.dm_wdata;
            if (v.dm_req) exp_q.push_back('{we: v.dm_we, be: (v.dm_we ? v.dm_be : 4'hF),
                                            addr: v.dm_addr, wdata: v.dm_wdata});
            if (v.if_req) exp_q.push_back('{we: 1'b0, be: 4'hF, addr: v.if_addr, wdata: 32'h0});
            done = 1'b0;
            if_w = 0;
            dm_w = 0;
            for (int c = 0; c < 60 && !done; c++) begin
                if (c > 0) step();
                sample();
                if (rom_wait) if_w++;
                if (ram_wait) dm_w++;
                else if (v.dm_req && rom_wait)
                    chk($sformatf("v%0d_partial_dm_rdata", i), 64'(dm_rdata), 64'(v.exp_dm));
                if (!rom_wait && !ram_wait) done = 1'b1;
            end
            chk($sformatf("v%0d_advance", i), 64'(done), 64'd1);
            if (v.if_req) chk($sformatf("v%0d_if_rdata", i), 64'(if_rdata), 64'(v.exp_if));
            if (v.dm_req) chk($sformatf("v%0d_dm_rdata", i), 64'(dm_rdata), 64'(v.exp_dm));
            if (v.exp_if_w >= 0) chk($sformatf("v%0d_rom_wait_cycles", i), 64'(if_w), 64'(v.exp_if_w));
            if (v.exp_dm_w >= 0) chk($sformatf("v%0d_ram_wait_cycles", i), 64'(dm_w), 64'(v.exp_dm_w));
            if (v.if_req && v.dm_req) chk($sformatf("v%0d_data_first", i), 64'(dm_w < if_w), 64'd1);
        end
        step();
        if_req = 1'b0;
        dm_req = 1'b0;
        sample();

        // Reset while a load is outstanding; the ack lands the cycle after reset.
        step();
        lat = 0;
        mem_hold = 1'b1;
        dm_req = 1'b1;
        dm_we = 1'b0;
        dm_be = 4'h0;
        dm_addr = 32'h3000;
        dm_wdata = 32'h0;
        exp_q.push_back('{we: 1'b0, be: 4'hF, addr: 32'h3000, wdata: 32'h0});
        exp_q.push_back('{we: 1'b0, be: 4'hF, addr: 32'h3000, wdata: 32'h0});
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            step();
            sample();
            if (bus_req) got = 1'b1;
        end
        chk("rst_mid_grant", 64'(got), 64'd1);
        step();
        sample();
        step();
        reset = 1'b1;
        sample();
        force_ack = 1'b1;
        step();
        reset = 1'b0;
        sample();
        force_ack = 1'b0;
        mem_hold = 1'b0;
        chk("rst_mid_bus_req", 64'(bus_req), 64'd0);
        chk("rst_mid_ram_wait", 64'(ram_wait), 64'd1);
        chk("rst_mid_dm_rdata", 64'(dm_rdata), 64'd0);
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            step();
            sample();
            if (!ram_wait) done = 1'b1;
        end
        chk("rst_mid_regrant_done", 64'(done), 64'd1);
        chk("rst_mid_dm_rdata_after", 64'(dm_rdata), 64'(mem_f(32'h3000)));
        step();
        dm_req = 1'b0;
        sample();

        // Fetch withdrawn mid-transaction: result discarded, next fetch is new.
        step();
        lat = 2;
        if_req = 1'b1;
        if_addr = 32'h500;
        exp_q.push_back('{we: 1'b0, be: 4'hF, addr: 32'h500, wdata: 32'h0});
        step();
        sample();
        chk("wd_bus_req", 64'(bus_req), 64'd1);
        step();
        if_req = 1'b0;
        sample();
        chk("wd_rom_wait_dropped", 64'(rom_wait), 64'd0);
        step();
        sample();
        step();
        sample();
        chk("wd_bus_idle", 64'(bus_req), 64'd0);
        chk("wd_waits", 64'({rom_wait, ram_wait}), 64'd0);
        chk("wd_if_rdata", 64'(if_rdata), 64'(mem_f(32'h500)));
        step();
        if_req = 1'b1;
        if_addr = 32'h504;
        exp_q.push_back('{we: 1'b0, be: 4'hF, addr: 32'h504, wdata: 32'h0});
        sample();
        chk("wd_new_req_waits", 64'(rom_wait), 64'd1);
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            step();
            sample();
            if (!rom_wait) done = 1'b1;
        end
        chk("wd_new_done", 64'(done), 64'd1);
        chk("wd_new_if_rdata", 64'(if_rdata), 64'(mem_f(32'h504)));
        step();
        if_req = 1'b0;
        sample();

        // Starvation: fetch pending while data keeps re-requesting.
        step();
        lat = 1;
        if_req = 1'b1;
        if_addr = 32'h600;
        dm_req = 1'b1;
        dm_we = 1'b0;
        dm_addr = 32'h700;
        for (int k = 0; k < 4; k++)
            exp_q.push_back('{we: 1'b0, be: 4'hF, addr: 32'h700 + 32'(4 * k), wdata: 32'h0});
        exp_q.push_back('{we: 1'b0, be: 4'hF, addr: 32'h600, wdata: 32'h0});
        exp_q.push_back('{we: 1'b0, be: 4'hF, addr: 32'h710, wdata: 32'h0});
        for (int k = 0; k < 4; k++) begin
            got = 1'b0;
            for (int c = 0; c < 20 && !got; c++) begin
                step();
                sample();
                if (bus_req) got = 1'b1;
            end
            chk($sformatf("starve_grant%0d", k), 64'(got), 64'd1);
            chk($sformatf("starve_cnt%0d", k), 64'(dut.starve_cnt), 64'(k + 1));
            step();
            dm_req = 1'b0;
            sample();
            step();
            dm_req = 1'b1;
            dm_addr = 32'h700 + 32'(4 * (k + 1));
            sample();
        end
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            step();
            sample();
            if (bus_req) got = 1'b1;
        end
        chk("starve_fetch_grant", 64'(got), 64'd1);
        chk("starve_fetch_addr", 64'(bus_addr), 64'h600);
        chk("starve_cnt_cleared", 64'(dut.starve_cnt), 64'd0);
        done = 1'b0;
        for (int c = 0; c < 30 && !done; c++) begin
            step();
            sample();
            if (!rom_wait && !ram_wait) done = 1'b1;
        end
        chk("starve_advance", 64'(done), 64'd1);
        chk("starve_if_rdata", 64'(if_rdata), 64'(mem_f(32'h600)));
        chk("starve_dm_rdata", 64'(dm_rdata), 64'(mem_f(32'h710)));
        step();
        if_req = 1'b0;
        dm_req = 1'b0;
        sample();

        repeat (3) begin
            step();
            sample();
        end
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        chk("bus_held_until_ack", 64'(hold_err), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
